// File: rtl/cdclib_hs_pkg.sv
// Shared types and helpers for the toggle req/ack handshake library.
// Holds the transmitter FSM encoding and watchdog counter sizing.
package cdclib_hs_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } hs_state_e;

  localparam int unsigned SYNC_STAGES_DEF = 4;

  // Smallest counter width that can represent the value TIMEOUT_CYC.
  function automatic int unsigned cnt_w_for(input int unsigned timeout_cyc);
    int unsigned w;
    w = $clog2(timeout_cyc + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cdclib_sync_srst.sv
// N-stage single-bit synchronizer with synchronous active-high reset.
// Output is the last flop of the chain.
module cdclib_sync_srst #(
  parameter int unsigned STAGES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // NOTE: flops take <= so every stage samples the pre-edge value of its neighbour.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdclib_hs_tx.sv
// Source-domain side of a two-phase req/ack handshake: launches a held word,
// waits for the synchronized ack toggle, and flags stalled transfers.
module cdclib_hs_tx
  import cdclib_hs_pkg::*;
#(
  parameter int unsigned DWIDTH      = 8,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  output logic              in_ready,
  output logic              tx_req,
  output logic [DWIDTH-1:0] tx_data,
  input  logic              ack_async,
  output logic              busy,
  output logic              timeout_err,
  input  logic              timeout_clr
);

  localparam logic             WDOG_EN  = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  hs_state_e         state_q, state_d;
  logic              tx_req_q, tx_req_d;
  logic [DWIDTH-1:0] tx_data_q, tx_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              ack_sync;
  logic              ready;
  logic              wdog_hit;

  cdclib_sync_srst #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d_i (ack_async),
    .q_o (ack_sync)
  );

  // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    tx_req_d  = tx_req_q;
    tx_data_d = tx_data_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    ready     = 1'b0;
    wdog_hit  = 1'b0;

    case (state_q)
      IDLE: begin
        // A mismatch here is a stale ack still crossing; hold off the launch.
        ready = (ack_sync == tx_req_q);
        if (in_valid && ready) begin
          tx_data_d = in_data;
          tx_req_d  = ~tx_req_q;
          cnt_d     = '0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        wdog_hit = WDOG_EN && (cnt_q == CNT_LAST);
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        if (ack_sync == tx_req_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Setting outranks clearing when both land on the same edge.
    if (wdog_hit)         err_d = 1'b1;
    else if (timeout_clr) err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_req_q  <= 1'b0;
      tx_data_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_req_q  <= tx_req_d;
      tx_data_q <= tx_data_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign in_ready    = ready;
  assign tx_req      = tx_req_q;
  assign tx_data     = tx_data_q;
  assign busy        = (state_q == WAIT);
  assign timeout_err = err_q;

endmodule
